// File: rtl/frame_mask_dbuf_if.sv
// Config, swap-control and pixel-query signals of the double-buffered frame mask.
// The slave side is the mask block; the master side is the APB logic plus the Stonyman driver.
interface frame_mask_dbuf_if #(
  parameter int AW     = 9,
  parameter int WORD_W = 32,
  parameter int RW     = 7,
  parameter int CW     = 7
);
  logic              cfg_wr_en;
  logic [AW-1:0]     cfg_wr_addr;
  logic [WORD_W-1:0] cfg_wr_data;
  logic              cfg_rd_en;
  logic [AW-1:0]     cfg_rd_addr;
  logic [WORD_W-1:0] cfg_rd_data;
  logic              cfg_rd_valid;
  logic              swap_req;
  logic              swap_pending;
  logic              active_bank;
  logic [1:0]        mode;
  logic [1:0]        dec;
  logic              frame_start;
  logic              pix_req;
  logic [RW-1:0]     pix_row;
  logic [CW-1:0]     pix_col;
  logic              pix_ack;
  logic              is_valid;

  modport slave (
    input  cfg_wr_en, cfg_wr_addr, cfg_wr_data, cfg_rd_en, cfg_rd_addr,
           swap_req, mode, dec, frame_start, pix_req, pix_row, pix_col,
    output cfg_rd_data, cfg_rd_valid, swap_pending, active_bank, pix_ack, is_valid
  );

  modport master (
    output cfg_wr_en, cfg_wr_addr, cfg_wr_data, cfg_rd_en, cfg_rd_addr,
           swap_req, mode, dec, frame_start, pix_req, pix_row, pix_col,
    input  cfg_rd_data, cfg_rd_valid, swap_pending, active_bank, pix_ack, is_valid
  );
endinterface

// File: rtl/frame_mask_dbuf.sv
// Double-buffered per-pixel validity mask: config writes the shadow bank, queries read the
// active bank through a fixed 3-stage pipeline; banks swap only at frame_start.
module frame_mask_dbuf #(
  parameter int ROWS   = 112,
  parameter int COLS   = 112,
  parameter int WORD_W = 32,
  parameter int NWORDS = (ROWS*COLS + WORD_W - 1) / WORD_W,
  parameter int AW     = $clog2(NWORDS),
  parameter int RW     = $clog2(ROWS),
  parameter int CW     = $clog2(COLS)
) (
  input  logic PCLK,
  input  logic PRESETn,
  frame_mask_dbuf_if.slave bus
);
  localparam int LW     = $clog2(WORD_W);
  localparam int IW     = RW + CW + 1;
  localparam int STAGES = 3;
  localparam logic [AW:0] NW_L   = (AW+1)'(NWORDS);
  localparam logic [RW:0] ROWS_L = (RW+1)'(ROWS);
  localparam logic [CW:0] COLS_L = (CW+1)'(COLS);

  typedef enum logic [1:0] {M_ALL, M_MASK, M_INV, M_DEC} mode_t;

  logic [WORD_W-1:0] bank0 [NWORDS];
  logic [WORD_W-1:0] bank1 [NWORDS];

  mode_t       mode_act;
  logic [1:0]  dec_act;

  // ---------------- swap / mode latching ----------------
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      bus.active_bank  <= 1'b0;
      bus.swap_pending <= 1'b0;
      mode_act         <= M_ALL;
      dec_act          <= 2'd0;
    end else if (bus.frame_start) begin
      mode_act         <= mode_t'(bus.mode);
      dec_act          <= bus.dec;
      if (bus.swap_pending || bus.swap_req) bus.active_bank <= ~bus.active_bank;
      bus.swap_pending <= 1'b0;
    end else if (bus.swap_req) begin
      bus.swap_pending <= 1'b1;
    end
  end

  // ---------------- config port (shadow bank only) ----------------
  logic              shadow, wr_ok, rd_in, rd_vld1, rd_in1;
  logic [AW-1:0]     rd_idx;
  logic [WORD_W-1:0] rd_word;

  assign shadow = ~bus.active_bank;
  assign wr_ok  = bus.cfg_wr_en && ({1'b0, bus.cfg_wr_addr} < NW_L);
  assign rd_in  = {1'b0, bus.cfg_rd_addr} < NW_L;
  assign rd_idx = rd_in ? bus.cfg_rd_addr : '0;

  // ---------------- query stage 1 ----------------
  logic [STAGES:1]   vld_pipe;
  logic [IW-1:0]     idx;
  logic              range_ok, dec_ok;
  logic [2:0]        dmask;
  logic [AW-1:0]     s1_word;
  logic [LW-1:0]     s1_bit, s2_bit;
  logic              s1_range, s1_dec, s1_bank, s2_range, s2_dec;
  mode_t             s1_mode, s2_mode;
  logic [WORD_W-1:0] pix_word;
  logic              m, hit;

  assign idx      = IW'(bus.pix_row) * IW'(COLS) + IW'(bus.pix_col);
  assign range_ok = ({1'b0, bus.pix_row} < ROWS_L) && ({1'b0, bus.pix_col} < COLS_L);
  assign dmask    = 3'((4'd1 << dec_act) - 4'd1);
  assign dec_ok   = ((bus.pix_row[2:0] | bus.pix_col[2:0]) & dmask) == 3'd0;

  // RAM arrays: no reset, writes and both synchronous reads
  always_ff @(posedge PCLK) begin
    if (wr_ok) begin
      if (shadow) bank1[bus.cfg_wr_addr] <= bus.cfg_wr_data;
      else        bank0[bus.cfg_wr_addr] <= bus.cfg_wr_data;
    end
    rd_word  <= shadow  ? bank1[rd_idx]  : bank0[rd_idx];
    pix_word <= s1_bank ? bank1[s1_word] : bank0[s1_word];
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      rd_vld1          <= 1'b0;
      rd_in1           <= 1'b0;
      bus.cfg_rd_valid <= 1'b0;
      bus.cfg_rd_data  <= '0;
    end else begin
      rd_vld1          <= bus.cfg_rd_en;
      rd_in1           <= rd_in;
      bus.cfg_rd_valid <= rd_vld1;
      bus.cfg_rd_data  <= (rd_vld1 && rd_in1) ? rd_word : '0;
    end
  end

  // ---------------- query stages ----------------
  always_comb begin
    m   = pix_word[s2_bit];
    hit = 1'b0;
    case (s2_mode)
      M_ALL:   hit = s2_range;
      M_MASK:  hit = s2_range & m;
      M_INV:   hit = s2_range & ~m;
      M_DEC:   hit = s2_range & m & s2_dec;
      default: hit = 1'b0;
    endcase
  end

  // Bank and mode are captured with the query, so a swap never retargets an in-flight lookup.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      vld_pipe     <= '0;
      s1_word      <= '0;
      s1_bit       <= '0;
      s1_range     <= 1'b0;
      s1_dec       <= 1'b0;
      s1_bank      <= 1'b0;
      s1_mode      <= M_ALL;
      s2_bit       <= '0;
      s2_range     <= 1'b0;
      s2_dec       <= 1'b0;
      s2_mode      <= M_ALL;
      bus.is_valid <= 1'b0;
    end else begin
      vld_pipe     <= {vld_pipe[STAGES-1:1], bus.pix_req};
      s1_word      <= range_ok ? AW'(idx >> LW) : '0;
      s1_bit       <= idx[LW-1:0];
      s1_range     <= range_ok;
      s1_dec       <= dec_ok;
      s1_bank      <= bus.active_bank;
      s1_mode      <= mode_act;
      s2_bit       <= s1_bit;
      s2_range     <= s1_range;
      s2_dec       <= s1_dec;
      s2_mode      <= s1_mode;
      bus.is_valid <= vld_pipe[2] & hit;
    end
  end

  assign bus.pix_ack = vld_pipe[STAGES];
endmodule
